dbram_frame_loader: RTL and testbench

Ping-pong frame controller sitting directly in front of the 2048x40 dual-port frame memory. It accepts a valid/ready stream of 40-bit words, writes fixed-length frames alternately into the lower and upper bank via memory port A, and drains completed frames through memory port B as a valid/ready output stream. Writing one bank overlaps with reading the other.

---
 rtl/dbram_frame_loader.sv | 175 +++++++++++++++++
 tb/tb_dbram_frame_loader.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dbram_frame_loader.sv
// Ping-pong frame loader in front of a two-bank dual-port frame memory: port A fills one bank
// while port B drains the other. Optional word parity is enabled by DBRAM_FRAME_LOADER_PARITY_EN.
module dbram_frame_loader #(
    parameter int AWIDTH    = 11,
    parameter int DWIDTH    = 40,
    parameter int FRAME_LEN = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DWIDTH-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DWIDTH-1:0] out_data,
    output logic              out_last,
    output logic [AWIDTH-1:0] mem_address_a,
    output logic              mem_wren_a,
    output logic [DWIDTH-1:0] mem_data_a,
    output logic [AWIDTH-1:0] mem_address_b,
    output logic              mem_wren_b,
    input  logic [DWIDTH-1:0] mem_out_b,
    output logic [1:0]        bank_full,
    output logic [15:0]       frames_done
);

    localparam int IW = AWIDTH - 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(FRAME_LEN - 1);

    typedef enum logic [1:0] {IDLE, READ, DRAIN} rd_state_t;

    rd_state_t         state, state_nxt;
    logic              wr_bank, rd_bank;
    logic [IW-1:0]     wr_idx, rd_idx;
    logic              wr_fire, wr_last;
    logic              issue, issue_last;
    logic              inflight, inflight_last;
    logic [2:0]        used;
    logic [1:0]        set_mask, clr_mask;
    logic [DWIDTH-1:0] skid_data [2];
    logic [1:0]        skid_last;
    logic              skid_wr_ptr, skid_rd_ptr;
    logic [1:0]        skid_count;
    logic              push, pop;
    logic [15:0]       frame_cnt;

    // ---------------- write side (combinational onto port A) ----------------
    assign in_ready      = !reset && !bank_full[wr_bank];
    assign wr_fire       = in_valid && in_ready;
    assign wr_last       = wr_fire && (wr_idx == LAST_IDX);
    assign mem_wren_a    = wr_fire;
    assign mem_address_a = {wr_bank, wr_idx};

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_bank <= 1'b0;
            wr_idx  <= '0;
        end else if (wr_fire) begin
            if (wr_last) begin
                wr_bank <= ~wr_bank;
                wr_idx  <= '0;
            end else begin
                wr_idx <= wr_idx + IW'(1);
            end
        end
    end

    // Writer and reader always touch different banks, so set and clear never collide.
    assign set_mask = wr_last    ? (wr_bank ? 2'b10 : 2'b01) : 2'b00;
    assign clr_mask = issue_last ? (rd_bank ? 2'b10 : 2'b01) : 2'b00;

    always_ff @(posedge clk) begin
        if (reset) bank_full <= 2'b00;
        else       bank_full <= (bank_full | set_mask) & ~clr_mask;
    end

    // ---------------- read side ----------------
    // Credit counts the word leaving the skid this cycle, which sustains one read per cycle.
    assign pop  = out_valid && out_ready;
    assign used = {1'b0, skid_count} + {2'b00, inflight} - {2'b00, pop};

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        state_nxt = state;
        issue     = 1'b0;
        case (state)
            IDLE:    if (bank_full[rd_bank]) state_nxt = READ;
            READ: begin
                issue = (used < 3'd2);
                if (issue && (rd_idx == LAST_IDX)) state_nxt = DRAIN;
            end
            DRAIN:   state_nxt = IDLE;  // the single in-flight word is captured during this cycle
            default: state_nxt = IDLE;
        endcase
    end

    assign issue_last    = issue && (rd_idx == LAST_IDX);
    assign mem_address_b = {rd_bank, rd_idx};
    assign mem_wren_b    = 1'b0;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state         <= IDLE;
            rd_bank       <= 1'b0;
            rd_idx        <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            state         <= state_nxt;
            inflight      <= issue;
            inflight_last <= issue_last;
            if (issue) begin
                if (issue_last) begin
                    rd_bank <= ~rd_bank;
                    rd_idx  <= '0;
                end else begin
                    rd_idx <= rd_idx + IW'(1);
                end
            end
        end
    end

    // ---------------- two-entry skid buffer ----------------
    assign push = inflight;

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: this two-word store is reset (unlike the frame memory) so out_data reads 0 out of reset.
            skid_data[0] <= '0;
            skid_data[1] <= '0;
            skid_last    <= 2'b00;
            skid_wr_ptr  <= 1'b0;
            skid_rd_ptr  <= 1'b0;
            skid_count   <= 2'd0;
        end else begin
            if (push) begin
                skid_data[skid_wr_ptr] <= mem_out_b;
                skid_last[skid_wr_ptr] <= inflight_last;
                skid_wr_ptr            <= ~skid_wr_ptr;
            end
            if (pop) skid_rd_ptr <= ~skid_rd_ptr;
            skid_count <= skid_count + {1'b0, push} - {1'b0, pop};
        end
    end

    assign out_valid = (skid_count != 2'd0);
    assign out_data  = skid_data[skid_rd_ptr];
    assign out_last  = out_valid && skid_last[skid_rd_ptr];

    always_ff @(posedge clk) begin
        if (reset)                frame_cnt <= 16'd0;
        else if (pop && out_last) frame_cnt <= frame_cnt + 16'd1;
    end

`ifdef DBRAM_FRAME_LOADER_PARITY_EN
    logic par_err;
    logic unused_in_msb;

    // Top data bit is replaced by even parity over the payload bits.
    assign unused_in_msb = in_data[DWIDTH-1];
    assign mem_data_a    = {^in_data[DWIDTH-2:0], in_data[DWIDTH-2:0]};

    always_ff @(posedge clk) begin
        if (reset)                   par_err <= 1'b0;
        else if (push && ^mem_out_b) par_err <= 1'b1;
    end

    assign frames_done = {frame_cnt[15] | par_err, frame_cnt[14:0]};
`else
    assign mem_data_a  = in_data;
    assign frames_done = frame_cnt;
`endif

endmodule

// File: tb/tb_dbram_frame_loader.sv
// Directed bench for dbram_frame_loader with FRAME_LEN=4 and a behavioural 2048x40 frame memory.
module tb_dbram_frame_loader;

    localparam int AW = 11;
    localparam int DW = 40;
    localparam int FL = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic [AW-1:0] mem_address_a;
    logic          mem_wren_a;
    logic [DW-1:0] mem_data_a;
    logic [AW-1:0] mem_address_b;
    logic          mem_wren_b;
    logic [DW-1:0] mem_out_b;
    logic [1:0]    bank_full;
    logic [15:0]   frames_done;

    int total = 0;
    int bad   = 0;

    dbram_frame_loader #(.AWIDTH(AW), .DWIDTH(DW), .FRAME_LEN(FL)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .mem_address_a(mem_address_a), .mem_wren_a(mem_wren_a), .mem_data_a(mem_data_a),
        .mem_address_b(mem_address_b), .mem_wren_b(mem_wren_b), .mem_out_b(mem_out_b),
        .bank_full(bank_full), .frames_done(frames_done)
    );

    always #5 clk = ~clk;

    // Frame memory: synchronous write on A, registered read on B with an injectable bit flip.
    logic [DW-1:0] mem [0:2047];
    logic [DW-1:0] flip_mask = '0;
    always @(posedge clk) begin
        if (mem_wren_a) mem[mem_address_a] <= mem_data_a;
        mem_out_b <= mem[mem_address_b] ^ flip_mask;
    end

    // Negedge monitor: logs writes and accepted outputs, counts reads issued, tracks latency.
    int            n_wr = 0, n_out = 0, issues = 0, ahead_viol = 0, cyc = 0;
    int            last_bf_rise = 0, last_valid_rise = 0;
    logic [AW-1:0] wr_addr_log [0:255];
    logic [DW-1:0] wr_data_log [0:255];
    logic [DW-1:0] out_log     [0:255];
    logic          out_last_log[0:255];
    logic [AW-1:0] prev_addr_b = '0;
    logic [1:0]    prev_bf = 2'b00;
    logic          prev_valid = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (reset) issues = n_out;
        else if (mem_address_b !== prev_addr_b) issues++;
        prev_addr_b = mem_address_b;
        if (!reset && (issues - n_out > 2)) ahead_viol++;
        if ((bank_full & ~prev_bf) != 2'b00) last_bf_rise = cyc;
        if (out_valid && !prev_valid) last_valid_rise = cyc;
        prev_bf    = bank_full;
        prev_valid = out_valid;
        if (!reset && mem_wren_a && n_wr < 256) begin
            wr_addr_log[n_wr] = mem_address_a;
            wr_data_log[n_wr] = mem_data_a;
            n_wr++;
        end
        if (!reset && out_valid && out_ready && n_out < 256) begin
            out_log[n_out]      = out_data;
            out_last_log[n_out] = out_last;
            n_out++;
        end
    end

    function automatic logic [DW-1:0] stored(input logic [DW-1:0] d);
`ifdef DBRAM_FRAME_LOADER_PARITY_EN
        return {^d[DW-2:0], d[DW-2:0]};
`else
        return d;
`endif
    endfunction

    task automatic do_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic send_word(input logic [DW-1:0] d);
        int waited;
        waited   = 0;
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        while (!in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        total++;
        if (!in_ready) begin
            bad++;
            $display("FAIL send_timeout data=%h in_ready=%b required=1", d, in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int quiet, n;
        quiet = 0;
        n     = 0;
        while (quiet < 4 && n < 500) begin
            @(negedge clk);
            n++;
            if (!out_valid && bank_full == 2'b00) quiet++;
            else quiet = 0;
        end
        total++;
        if (quiet < 4) begin
            bad++;
            $display("FAIL drain_timeout out_valid=%b bank_full=%b required idle", out_valid, bank_full);
        end
    endtask

    // Checks a run of n outputs starting at log index ob against base+i, out_last every FL words.
    task automatic check_outputs(input string name, input int ob, input logic [DW-1:0] base,
                                 input int n, input logic [DW-1:0] flip);
        logic [DW-1:0] exp;
        total++;
        if (n_out - ob !== n) begin
            bad++;
            $display("FAIL %s_count got=%0d required=%0d", name, n_out - ob, n);
        end
        for (int i = 0; i < n; i++) begin
            exp = stored(base + DW'(i)) ^ flip;
            total++;
            if (out_log[ob+i] !== exp || out_last_log[ob+i] !== (i % FL == FL - 1)) begin
                bad++;
                $display("FAIL %s_word[%0d] got=%h last=%b required=%h last=%b", name, i,
                         out_log[ob+i], out_last_log[ob+i], exp, (i % FL == FL - 1));
            end
        end
    endtask

    task automatic test_reset();
        in_valid = 1'b1;
        in_data  = 40'h12_3456_789A;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        total++;
        if (in_ready !== 1'b0 || mem_wren_a !== 1'b0 || out_valid !== 1'b0 || out_last !== 1'b0) begin
            bad++;
            $display("FAIL reset_handshake in_ready=%b wren_a=%b out_valid=%b out_last=%b required 0000",
                     in_ready, mem_wren_a, out_valid, out_last);
        end
        total++;
        if (out_data !== '0 || mem_address_a !== '0 || mem_address_b !== '0 || mem_wren_b !== 1'b0) begin
            bad++;
            $display("FAIL reset_ports out_data=%h addr_a=%h addr_b=%h wren_b=%b required zeros",
                     out_data, mem_address_a, mem_address_b, mem_wren_b);
        end
        total++;
        if (bank_full !== 2'b00 || frames_done !== 16'd0) begin
            bad++;
            $display("FAIL reset_state bank_full=%b frames_done=%0d required 00/0", bank_full, frames_done);
        end
        total++;
        if (mem_data_a !== stored(in_data)) begin
            bad++;
            $display("FAIL reset_data_a got=%h required=%h", mem_data_a, stored(in_data));
        end
        in_valid = 1'b0;
        do_reset();
    endtask

    task automatic test_single_frame();
        int wb, ob;
        do_reset();
        out_ready = 1'b1;
        wb = n_wr;
        ob = n_out;
        for (int i = 0; i < FL; i++) send_word(DW'(i + 1));
        @(negedge clk);
        total++;
        if (bank_full !== 2'b01) begin
            bad++;
            $display("FAIL single_bank_full got=%b required=01", bank_full);
        end
        wait_drain();
        for (int i = 0; i < FL; i++) begin
            total++;
            if (wr_addr_log[wb+i] !== AW'(i) || wr_data_log[wb+i] !== stored(DW'(i + 1))) begin
                bad++;
                $display("FAIL single_write[%0d] addr=%h data=%h required %h/%h", i,
                         wr_addr_log[wb+i], wr_data_log[wb+i], AW'(i), stored(DW'(i + 1)));
            end
        end
        check_outputs("single", ob, DW'(1), FL, '0);
        total++;
        if (last_valid_rise - last_bf_rise !== 3) begin
            bad++;
            $display("FAIL single_latency got=%0d required=3", last_valid_rise - last_bf_rise);
        end
        total++;
        if (frames_done !== 16'd1) begin
            bad++;
            $display("FAIL single_frames_done got=%0d required=1", frames_done);
        end
    endtask

    task automatic test_backpressure();
        int wb, ob;
        logic [AW-1:0] ea;
        do_reset();
        wb = n_wr;
        ob = n_out;
        fork
            for (int i = 0; i < 3 * FL; i++) send_word(DW'(32'h10 + i));
            begin
                repeat (20) @(negedge clk);
                total++;
                if (bank_full !== 2'b11 || in_ready !== 1'b0) begin
                    bad++;
                    $display("FAIL bp_both_full bank_full=%b in_ready=%b required 11/0", bank_full, in_ready);
                end
                total++;
                if (n_wr - wb !== 2 * FL || n_out - ob !== 0) begin
                    bad++;
                    $display("FAIL bp_stall writes=%0d outputs=%0d required 8/0", n_wr - wb, n_out - ob);
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        wait_drain();
        total++;
        if (n_wr - wb !== 3 * FL) begin
            bad++;
            $display("FAIL bp_write_count got=%0d required=12", n_wr - wb);
        end
        for (int i = 0; i < 3 * FL; i++) begin
            ea = AW'(((i / FL) % 2) * 1024 + (i % FL));
            total++;
            if (wr_addr_log[wb+i] !== ea || wr_data_log[wb+i] !== stored(DW'(32'h10 + i))) begin
                bad++;
                $display("FAIL bp_write[%0d] addr=%h data=%h required %h/%h", i, wr_addr_log[wb+i],
                         wr_data_log[wb+i], ea, stored(DW'(32'h10 + i)));
            end
        end
        check_outputs("bp", ob, DW'(32'h10), 3 * FL, '0);
        total++;
        if (frames_done !== 16'd3) begin
            bad++;
            $display("FAIL bp_frames_done got=%0d required=3", frames_done);
        end
    endtask

    task automatic test_toggle_ready();
        int ob, vb;
        do_reset();
        ob = n_out;
        vb = ahead_viol;
        for (int i = 0; i < FL; i++) send_word(DW'(32'hA0 + i));
        for (int i = 0; i < 24; i++) begin
            @(posedge clk); #1;
            out_ready = (i % 2 == 0);
        end
        out_ready = 1'b1;
        wait_drain();
        check_outputs("toggle", ob, DW'(32'hA0), FL, '0);
        total++;
        if (ahead_viol !== vb) begin
            bad++;
            $display("FAIL toggle_read_ahead violations=%0d required=0", ahead_viol - vb);
        end
    endtask

    task automatic test_back_to_back();
        int wb, ob;
        logic [AW-1:0] ea;
        do_reset();
        out_ready = 1'b1;
        wb = n_wr;
        ob = n_out;
        for (int i = 0; i < 10 * FL; i++) send_word(40'h80_0000_0100 + DW'(i));
        wait_drain();
        total++;
        if (n_wr - wb !== 10 * FL) begin
            bad++;
            $display("FAIL b2b_write_count got=%0d required=40", n_wr - wb);
        end
        for (int i = 0; i < 10 * FL; i++) begin
            ea = AW'(((i / FL) % 2) * 1024 + (i % FL));
            total++;
            if (wr_addr_log[wb+i] !== ea) begin
                bad++;
                $display("FAIL b2b_write_addr[%0d] got=%h required=%h", i, wr_addr_log[wb+i], ea);
            end
        end
        check_outputs("b2b", ob, 40'h80_0000_0100, 10 * FL, '0);
        total++;
        if (frames_done !== 16'd10) begin
            bad++;
            $display("FAIL b2b_frames_done got=%0d required=10", frames_done);
        end
    endtask

    task automatic test_mid_reset();
        int wb, ob;
        do_reset();
        for (int i = 0; i < FL; i++) send_word(DW'(32'h40 + i));
        send_word(DW'(32'h50));
        send_word(DW'(32'h51));
        repeat (4) @(negedge clk);
        total++;
        if (bank_full !== 2'b01 || out_valid !== 1'b1) begin
            bad++;
            $display("FAIL mid_pre_reset bank_full=%b out_valid=%b required 01/1", bank_full, out_valid);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b0) begin
            bad++;
            $display("FAIL mid_in_ready got=%b required=0", in_ready);
        end
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0 || bank_full !== 2'b00 || mem_address_a !== '0 || frames_done !== 16'd0) begin
            bad++;
            $display("FAIL mid_after_reset out_valid=%b bank_full=%b addr_a=%h frames=%0d required 0/00/0/0",
                     out_valid, bank_full, mem_address_a, frames_done);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        out_ready = 1'b1;
        wb = n_wr;
        ob = n_out;
        for (int i = 0; i < FL; i++) send_word(DW'(32'h60 + i));
        wait_drain();
        for (int i = 0; i < FL; i++) begin
            total++;
            if (wr_addr_log[wb+i] !== AW'(i)) begin
                bad++;
                $display("FAIL mid_write_addr[%0d] got=%h required=%h", i, wr_addr_log[wb+i], AW'(i));
            end
        end
        check_outputs("mid", ob, DW'(32'h60), FL, '0);
        total++;
        if (frames_done !== 16'd1) begin
            bad++;
            $display("FAIL mid_frames_done got=%0d required=1", frames_done);
        end
    endtask

`ifdef DBRAM_FRAME_LOADER_PARITY_EN
    task automatic test_parity();
        int ob;
        logic [DW-1:0] flip;
        flip = 40'h8;
        do_reset();
        out_ready = 1'b1;
        ob = n_out;
        flip_mask = flip;
        for (int i = 0; i < FL; i++) send_word(DW'(32'h70 + i));
        wait_drain();
        flip_mask = '0;
        check_outputs("parity_flip", ob, DW'(32'h70), FL, flip);
        total++;
        if (frames_done !== 16'h8001) begin
            bad++;
            $display("FAIL parity_flag got=%h required=8001", frames_done);
        end
        ob = n_out;
        for (int i = 0; i < FL; i++) send_word(DW'(32'h74 + i));
        wait_drain();
        check_outputs("parity_clean", ob, DW'(32'h74), FL, '0);
        total++;
        if (frames_done !== 16'h8002) begin
            bad++;
            $display("FAIL parity_sticky got=%h required=8002", frames_done);
        end
        do_reset();
        @(negedge clk);
        total++;
        if (frames_done !== 16'h0000) begin
            bad++;
            $display("FAIL parity_reset got=%h required=0000", frames_done);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_frame();
        test_backpressure();
        test_toggle_ready();
        test_back_to_back();
        test_mid_reset();
`ifdef DBRAM_FRAME_LOADER_PARITY_EN
        test_parity();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog_timeout time=%0t required finish", $time);
        $fatal(1, "watchdog");
    end

endmodule
